// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the register-file dump path.
package regfile_pkg;

  localparam int unsigned NUM_REGS      = 8;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BYTES_PER_REG = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/reg_dump_streamer_byte_serializer.sv
// Loads a word (or a single byte) and offers it LSB-first over valid/ready,
// holding data and valid steady while the sink stalls.
module reg_dump_streamer_byte_serializer #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              load_byte_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              tx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  output logic              drained_c_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              last_c, fire_c;

  assign last_c      = (cnt_q == CNT_W'(BYTES - 1));
  assign fire_c      = valid_q & tx_ready_i;
  assign drained_c_o = fire_c & last_c;
  assign tx_data_o   = shift_q[7:0];
  assign tx_valid_o  = valid_q;

  // A single-byte load starts at the last count so it drains after one beat.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = load_byte_i ? DATA_W'(load_data_i[7:0]) : load_data_i;
      cnt_d   = load_byte_i ? CNT_W'(BYTES - 1) : '0;
      valid_d = 1'b1;
    end else if (fire_c) begin
      if (last_c) begin
        valid_d = 1'b0;
      end else begin
        shift_d = shift_q >> 8;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Walks the register file read port and streams each register as bytes.
// Optional trailing XOR checksum byte when REG_DUMP_CHKSUM_EN is defined.
module reg_dump_streamer #(
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  output logic [ADDR_W-1:0] read_reg,
  input  logic [DATA_W-1:0] read_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  import regfile_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] reg_idx_q, reg_idx_d;
  logic              busy_q, done_q;
  logic              load_c, load_byte_c, drained_c;
  logic [DATA_W-1:0] load_data_c;
`ifdef REG_DUMP_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  reg_dump_streamer_byte_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .load_byte_i(load_byte_c),
    .load_data_i(load_data_c),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .drained_c_o(drained_c)
  );

  // Next-state and serializer control; read_reg returns to 0 once back in IDLE.
  always_comb begin
    state_d     = state_q;
    reg_idx_d   = reg_idx_q;
    load_c      = 1'b0;
    load_byte_c = 1'b0;
    load_data_c = read_data;
`ifdef REG_DUMP_CHKSUM_EN
    chk_d = chk_q;
    if (state_q == SEND && tx_valid && tx_ready) chk_d = chk_q ^ tx_data;
`endif
    case (state_q)
      IDLE: begin
        reg_idx_d = '0;
        if (dump_req) begin
          state_d = FETCH;
`ifdef REG_DUMP_CHKSUM_EN
          chk_d = '0;
`endif
        end
      end
      FETCH: begin
        load_c  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (drained_c) begin
          if (reg_idx_q != ADDR_W'(NUM_REGS - 1)) begin
            reg_idx_d = reg_idx_q + ADDR_W'(1);
            state_d   = FETCH;
          end else begin
`ifdef REG_DUMP_CHKSUM_EN
            state_d     = CHK;
            load_c      = 1'b1;
            load_byte_c = 1'b1;
            load_data_c = DATA_W'(chk_d);
`else
            state_d = DONE;
`endif
          end
        end
      end
      CHK: begin
        if (drained_c) state_d = DONE;
      end
      DONE: begin
        reg_idx_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      reg_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REG_DUMP_CHKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      reg_idx_q <= reg_idx_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
`ifdef REG_DUMP_CHKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign read_reg = reg_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Scoreboard bench for reg_dump_streamer with a behavioural register file.
module tb_reg_dump_streamer;

  import regfile_pkg::*;

`ifdef REG_DUMP_CHKSUM_EN
  localparam int unsigned EXP_CYC = NUM_REGS * (1 + BYTES_PER_REG) + 2;
`else
  localparam int unsigned EXP_CYC = NUM_REGS * (1 + BYTES_PER_REG) + 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dump_req = 1'b0;
  logic              tx_ready = 1'b1;
  logic [ADDR_W-1:0] read_reg;
  logic [DATA_W-1:0] read_data;
  logic [7:0]        tx_data;
  logic              tx_valid, busy, done;

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] exp_regs [NUM_REGS];
  logic [7:0]        exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int byte_cnt = 0;
  bit rdy_rand = 1'b0;

  assign read_data = rf[read_reg];

  always #5 clk = ~clk;

  reg_dump_streamer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dump_req (dump_req),
    .read_reg (read_reg),
    .read_data(read_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_dump();
    logic [7:0] x;
    x = '0;
    for (int r = 0; r < int'(NUM_REGS); r++)
      for (int b = 0; b < int'(BYTES_PER_REG); b++) begin
        exp_q.push_back(exp_regs[r][8*b +: 8]);
        x = x ^ exp_regs[r][8*b +: 8];
      end
`ifdef REG_DUMP_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c;
    c = 0;
    while (done_cnt < target && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Sink driver: ready changes just after the active edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on accepted bytes, checks stall stability and done/busy.
  initial begin
    bit         stall, prev_done;
    logic [7:0] stall_data, e;
    stall = 1'b0; prev_done = 1'b0; stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0; prev_done = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(stall_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d", byte_cnt), 32'(tx_data), 32'(e));
          end
          byte_cnt++;
        end
        stall = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (done) begin
          done_cnt++;
          check("busy_with_done", 32'(busy), 32'd1);
        end
        if (prev_done && !done) check("busy_after_done", 32'(busy), 32'd0);
        prev_done = done;
      end
    end
  end

  initial begin
    int cyc, seen, base, dn;
    for (int r = 0; r < int'(NUM_REGS); r++) rf[r] = {4{8'(r)}};
    rf[3] = 32'hDEADBEEF;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_read_reg", 32'(read_reg), 32'd0);
    check("idle_tx_data", 32'(tx_data), 32'd0);

    // Basic dump, ready high, latency and cycle count
    exp_regs = rf;
    push_dump();
    @(posedge clk); #1 dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
    @(negedge clk);
    cyc = 1;
    check("fetch_valid", 32'(tx_valid), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_read_reg", 32'(read_reg), 32'd0);
    @(negedge clk);
    cyc++;
    check("first_valid", 32'(tx_valid), 32'd1);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("dump_cycles", 32'(cyc), 32'(EXP_CYC));
    wait_done(1, 50);

    // Random backpressure
    rdy_rand = 1'b1;
    push_dump();
    pulse_req();
    wait_done(2, 2000);
    rdy_rand = 1'b0;

    // Requests while busy are ignored
    push_dump();
    pulse_req();
    repeat (4) begin
      repeat (6) @(posedge clk);
      pulse_req();
    end
    wait_done(3, 200);

    // Held request re-triggers once after done
    push_dump();
    push_dump();
    @(posedge clk); #1 dump_req = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) seen++;
    end
    dump_req = 1'b0;
    wait_done(5, 20);

    // Reset after the 10th byte aborts the dump
    push_dump();
    pulse_req();
    base = byte_cnt; cyc = 0;
    while (byte_cnt < base + 10 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("bytes_before_reset", 32'(byte_cnt), 32'(base + 10));
    dn = done_cnt;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_read_reg", 32'(read_reg), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_partial_done", 32'(done_cnt), 32'(dn));
    push_dump();
    pulse_req();
    wait_done(dn + 1, 200);

    // Write reg5 while reg2 is being sent
    exp_regs = rf;
    exp_regs[5] = 32'h12345678;
    push_dump();
    pulse_req();
    cyc = 0;
    while (!(read_reg == 3'd2 && tx_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_reg2", 32'(read_reg), 32'd2);
    rf[5] = 32'h12345678;
    wait_done(dn + 2, 200);

    // All A5: bytes cancel in the checksum
    for (int r = 0; r < int'(NUM_REGS); r++) rf[r] = 32'hA5A5A5A5;
    exp_regs = rf;
    push_dump();
    pulse_req();
    wait_done(dn + 3, 200);

    // Single set bit in reg0
    for (int r = 0; r < int'(NUM_REGS); r++) rf[r] = '0;
    rf[0] = 32'h00000001;
    exp_regs = rf;
    push_dump();
    pulse_req();
    wait_done(dn + 4, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
